// File: rtl/core_top.sv
// Single-cycle RV32I integer core: fetch, decode, execute and write back one instruction per clock.
// Define CORE_TRACE_EN to print a retirement trace line on every clock edge outside reset.

module core_ramgen #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] ram [DEPTH];

    // The array is normally filled by the simulator; the write port keeps it a proper memory.
    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    assign rdata = ram[raddr];
endmodule

module core_instcatch #(
    parameter int ROM_DEPTH = 4096
) (
    input  logic                         clk,
    input  logic [$clog2(ROM_DEPTH)-1:0] addr,
    output logic [31:0]                  instr
);
    localparam int AW = $clog2(ROM_DEPTH);

    core_ramgen #(.DEPTH(ROM_DEPTH), .AW(AW)) u_ramGen (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata (32'h0),
        .raddr (addr),
        .rdata (instr)
    );
endmodule

module core_instfetch #(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    localparam int AW = $clog2(ROM_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= next_pc;
    end

    // Byte offset bits are dropped and the word index wraps with the ROM size.
    core_instcatch #(.ROM_DEPTH(ROM_DEPTH)) u_InstCatch (
        .clk   (clk),
        .addr  (pc[AW+1:2]),
        .instr (instr)
    );
endmodule

module core_registers (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regfile [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regfile[i] <= 32'h0;
        end else if (we && (wa != 5'd0)) begin
            regfile[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regfile[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regfile[ra2];
endmodule

module core_top #(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc, instr, next_pc;
    logic [31:0] rs1v, rs2v, wdata;
    logic        wen;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] immI, immB, immU, immJ;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign immI   = {{20{instr[31]}}, instr[31:20]};
    assign immB   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU   = {instr[31:12], 12'h000};
    assign immJ   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: alu = alt ? (a - b) : (a + b);
            3'd1: alu = a << b[4:0];
            3'd2: alu = {31'h0, $signed(a) < $signed(b)};
            3'd3: alu = {31'h0, a < b};
            3'd4: alu = a ^ b;
            3'd5: alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: alu = a | b;
            3'd7: alu = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        case (f3)
            3'd0:    branch_taken = (a == b);
            3'd1:    branch_taken = (a != b);
            3'd4:    branch_taken = ($signed(a) < $signed(b));
            3'd5:    branch_taken = ($signed(a) >= $signed(b));
            3'd6:    branch_taken = (a < b);
            3'd7:    branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // Unrecognised opcodes fall through to the default: no write, pc advances by 4.
    always_comb begin
        wen     = 1'b0;
        wdata   = 32'h0;
        next_pc = pc + 32'd4;
        case (opcode)
            7'b0110111: begin wen = 1'b1; wdata = immU; end
            7'b0010111: begin wen = 1'b1; wdata = pc + immU; end
            7'b1101111: begin wen = 1'b1; wdata = pc + 32'd4; next_pc = pc + immJ; end
            7'b1100111: begin
                wen     = 1'b1;
                wdata   = pc + 32'd4;
                next_pc = (rs1v + immI) & ~32'd1;
            end
            7'b1100011: begin
                if (branch_taken(funct3, rs1v, rs2v)) next_pc = pc + immB;
            end
            7'b0010011: begin
                wen   = 1'b1;
                wdata = alu(rs1v, immI, funct3, (funct3 == 3'd5) && instr[30]);
            end
            7'b0110011: begin wen = 1'b1; wdata = alu(rs1v, rs2v, funct3, instr[30]); end
            default: ;
        endcase
    end

    core_instfetch #(.ROM_DEPTH(ROM_DEPTH), .RESET_PC(RESET_PC)) u_InstFetch (
        .clk     (clk),
        .rst     (rst),
        .next_pc (next_pc),
        .pc      (pc),
        .instr   (instr)
    );

    core_registers u_Registers (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .we  (wen),
        .wa  (rd),
        .wd  (wdata),
        .rd1 (rs1v),
        .rd2 (rs2v)
    );

`ifdef CORE_TRACE_EN
    always @(posedge clk) begin
        if (rst) begin
            if (wen) $display("[core] pc=%08h instr=%08h rd=x%0d wdata=%08h", pc, instr, rd, wdata);
            else     $display("[core] pc=%08h instr=%08h rd=x%0d wdata=-", pc, instr, rd);
        end
    end
`endif
endmodule

// File: tb/tb_core_top.sv
// Directed bench for core_top: small programs are written into the ROM, expected
// architectural state is queued on a scoreboard and compared against the core.

module tb_core_top;
    logic clk;
    logic rst;

    typedef struct {
        string       tag;
        int          idx;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    localparam int PC_IDX = 32;
    localparam int ROM_WORDS = 4096;

    core_top dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encI(input int imm, input int rs1, input int f3, input int rd,
                                         input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] encR(input int f7, input int rs2, input int rs1, input int f3,
                                         input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] encU(input int imm20, input int rd, input int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] encJ(input int off, input int rd);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] encB(input int off, input int rs2, input int rs1, input int f3);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
    endfunction

    task automatic fillRom(input logic [31:0] w);
        for (int i = 0; i < ROM_WORDS; i++) dut.u_InstFetch.u_InstCatch.u_ramGen.ram[i] <= w;
    endtask

    task automatic load(input int addr, input logic [31:0] w);
        dut.u_InstFetch.u_InstCatch.u_ramGen.ram[addr >> 2] <= w;
    endtask

    task automatic expectReg(input string tag, input int r, input logic [31:0] v);
        sb.push_back('{tag: tag, idx: r, exp: v});
    endtask

    task automatic expectPc(input string tag, input logic [31:0] v);
        sb.push_back('{tag: tag, idx: PC_IDX, exp: v});
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic enterReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkOutput();
        sb_item_t it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.idx == PC_IDX) obs = dut.u_InstFetch.pc;
            else                  obs = dut.u_Registers.regfile[it.idx];
            vectors++;
            assert (obs === it.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %08h expected %08h", it.tag, obs, it.exp);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        fillRom(32'hDEAD_BEEF);
        applyStimulus(3);

        // Reset with garbage ROM
        enterReset();
        applyStimulus(4);
        expectPc("reset_pc", 32'h0);
        for (int r = 0; r < 32; r++) expectReg($sformatf("reset_x%0d", r), r, 32'h0);
        checkOutput();

        // ALU immediates and x0 write discard
        fillRom(32'h0);
        load(32'h00, encI(5, 0, 0, 1, 7'h13));
        load(32'h04, encI(-7, 1, 0, 2, 7'h13));
        load(32'h08, encI(1, 0, 0, 0, 7'h13));
        load(32'h0C, encJ(0, 0));
        releaseReset();
        applyStimulus(2);
        expectReg("addi_x1", 1, 32'h5);
        expectReg("addi_x2", 2, 32'hFFFF_FFFE);
        expectPc("pc_after_2", 32'h8);
        checkOutput();
        applyStimulus(1);
        expectReg("x0_stays_0", 0, 32'h0);
        expectPc("pc_after_3", 32'hC);
        checkOutput();
        applyStimulus(3);
        expectPc("self_loop", 32'hC);
        checkOutput();

        // Asynchronous reset mid-run, away from any clock edge
        rst = 1'b0;
        #1;
        expectPc("async_reset_pc", 32'h0);
        expectReg("async_reset_x1", 1, 32'h0);
        expectReg("async_reset_x2", 2, 32'h0);
        checkOutput();
        applyStimulus(1);
        expectPc("reset_held_pc", 32'h0);
        checkOutput();

        // Upper immediates
        fillRom(32'h0);
        load(32'h00, encU('h12345, 5, 7'h37));
        load(32'h04, encI('h678, 5, 0, 5, 7'h13));
        load(32'h08, encU(1, 6, 7'h17));
        load(32'h0C, encJ(0, 0));
        releaseReset();
        applyStimulus(3);
        expectReg("lui_addi_x5", 5, 32'h1234_5678);
        expectReg("auipc_x6", 6, 32'h0000_1008);
        checkOutput();

        // Shifts and compares
        enterReset();
        fillRom(32'h0);
        load(32'h00, encU('h80000, 7, 7'h37));
        load(32'h04, encI('h404, 7, 5, 8, 7'h13));
        load(32'h08, encI(4, 7, 5, 9, 7'h13));
        load(32'h0C, encR(0, 0, 7, 2, 10));
        load(32'h10, encR(0, 0, 7, 3, 11));
        load(32'h14, encI(-1, 7, 4, 12, 7'h13));
        load(32'h18, encR('h20, 10, 0, 0, 13));
        load(32'h1C, encR('h20, 10, 7, 5, 14));
        load(32'h20, encJ(0, 0));
        releaseReset();
        applyStimulus(8);
        expectReg("lui_x7", 7, 32'h8000_0000);
        expectReg("srai_x8", 8, 32'hF800_0000);
        expectReg("srli_x9", 9, 32'h0800_0000);
        expectReg("slt_x10", 10, 32'h1);
        expectReg("sltu_x11", 11, 32'h0);
        expectReg("xori_x12", 12, 32'h7FFF_FFFF);
        expectReg("sub_x13", 13, 32'hFFFF_FFFF);
        expectReg("sra_x14", 14, 32'hC000_0000);
        expectPc("shift_loop_pc", 32'h20);
        checkOutput();

        // Control flow
        enterReset();
        fillRom(32'h0);
        load(32'h00, encI('h20, 0, 0, 2, 7'h13));
        load(32'h04, encB(8, 0, 0, 0));
        load(32'h08, encI(99, 0, 0, 20, 7'h13));
        load(32'h0C, encB(8, 0, 0, 1));
        load(32'h10, encJ(8, 1));
        load(32'h14, encI(77, 0, 0, 21, 7'h13));
        load(32'h18, encI(3, 2, 0, 0, 7'h67));
        load(32'h20, encI(55, 0, 0, 22, 7'h13));
        load(32'h24, encJ(0, 0));
        releaseReset();
        applyStimulus(2);
        expectPc("beq_taken", 32'hC);
        checkOutput();
        applyStimulus(1);
        expectPc("bne_fallthrough", 32'h10);
        checkOutput();
        applyStimulus(1);
        expectPc("jal_target", 32'h18);
        expectReg("jal_link", 1, 32'h14);
        checkOutput();
        applyStimulus(1);
        expectPc("jalr_target", 32'h22);
        checkOutput();
        applyStimulus(2);
        expectReg("jalr_fetch_word", 22, 32'd55);
        expectReg("beq_skipped", 20, 32'h0);
        expectReg("jal_skipped", 21, 32'h0);
        expectPc("misaligned_loop", 32'h26);
        checkOutput();

        // Self-checking compliance program
        enterReset();
        fillRom(32'h0);
        load(32'h00, encI(1, 0, 0, 3, 7'h13));
        load(32'h04, encI(-1, 0, 0, 1, 7'h13));
        load(32'h08, encI(1, 0, 0, 2, 7'h13));
        load(32'h0C, encB(8, 2, 1, 4));
        load(32'h10, encJ('h5C - 'h10, 0));
        load(32'h14, encI(2, 0, 0, 3, 7'h13));
        load(32'h18, encB('h5C - 'h18, 2, 1, 6));
        load(32'h1C, encI(3, 0, 0, 3, 7'h13));
        load(32'h20, encB(8, 2, 1, 7));
        load(32'h24, encJ('h5C - 'h24, 0));
        load(32'h28, encI(4, 0, 0, 3, 7'h13));
        load(32'h2C, encB(8, 1, 2, 5));
        load(32'h30, encJ('h5C - 'h30, 0));
        load(32'h34, encI(5, 0, 0, 3, 7'h13));
        load(32'h38, encR(0, 2, 1, 7, 4));
        load(32'h3C, encB('h5C - 'h3C, 2, 4, 1));
        load(32'h40, encI(6, 0, 0, 3, 7'h13));
        load(32'h44, encR(0, 1, 2, 1, 5));
        load(32'h48, encR(0, 1, 5, 5, 6));
        load(32'h4C, encB('h5C - 'h4C, 2, 6, 1));
        load(32'h50, encI(1, 0, 0, 26, 7'h13));
        load(32'h54, encI(1, 0, 0, 27, 7'h13));
        load(32'h58, encJ(0, 0));
        load(32'h5C, encI(1, 0, 0, 26, 7'h13));
        load(32'h60, encJ(0, 0));
        releaseReset();
        for (int c = 0; c < 1500; c++) begin
            if (dut.u_Registers.regfile[26] == 32'h1) break;
            applyStimulus(1);
        end
        applyStimulus(4);
        expectReg("done_x26", 26, 32'h1);
        expectReg("pass_x27", 27, 32'h1);
        expectReg("testnum_x3", 3, 32'h6);
        expectPc("end_loop_pc", 32'h58);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core_top.md
# core_top

Single-cycle RV32I integer core top level for simulation-based ISA compliance runs. It fetches from an internal word-addressed instruction ROM, decodes, executes and writes back one instruction per clock. It is the root of the core hierarchy and has no external bus. Test programs signal completion through architectural registers: x26 = 1 means done, x27 = 1 means pass, and x3 holds the current test number.

## Interface
- `ROM_DEPTH`, default 4096: instruction ROM depth in 32-bit words; must be a power of two.
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `clk` input, 1 bit: core clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low; clears PC and register file.
- No output ports. Observation is by hierarchical reference only, so these instance and array names are mandatory:
  - `u_Registers.regfile`: 32 x 32-bit array.
  - `u_InstFetch.u_InstCatch.u_ramGen.ram`: `ROM_DEPTH` x 32-bit array, loadable with `$readmemh`.

## Operation
- **Fetch**
  - ROM read is combinational: instr = ram[pc[log2(ROM_DEPTH)+1:2]].
  - pc[1:0] are ignored.
  - The index wraps modulo `ROM_DEPTH`.
- **Decode.** Supported classes: LUI, AUIPC, JAL, JALR, BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU), OP-IMM (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI), OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
- **Unsupported opcodes**, including LOAD, STORE, FENCE, SYSTEM and any unknown encoding:
  - No register write.
  - pc += 4.
- **Immediates.** I/S/B/U/J formats, sign-extended per the RV32I spec.
- **Arithmetic**
  - Results are 32-bit, modulo 2^32; no overflow trap.
  - Shift amount is operand[4:0].
  - SLT and BLT/BGE compare signed; SLTU and BLTU/BGEU compare unsigned.
- **Next PC**
  - Branch taken: pc + immB.
  - JAL: pc + immJ.
  - JALR: (rs1 + immI) & ~1.
  - All other instructions: pc + 4.
- **Link value.** JAL and JALR write pc + 4 to rd.
- **Register file**
  - Two combinational read ports and one write port.
  - x0 reads as 0 and writes to it are discarded.
  - Read-during-write in the same cycle returns the old value; correct for a single-cycle core.

## Timing
- CPI = 1. The instruction at pc retires at the next rising edge: rd and pc update together.
- On reset assertion, the following clear immediately, without waiting for a clock edge, and hold while asserted, including mid-instruction:
  - pc = `RESET_PC`.
  - All 32 registers = 0.
- First rising edge after deassertion executes the instruction at `RESET_PC`.
- ROM contents are not affected by reset.
- A branch or jump to the same pc is a legal self-loop and repeats every cycle. It is the normal end-of-test idiom.

## Configuration
- `CORE_TRACE_EN` defined:
  - On every retiring edge, emit one `$display` line: pc, instr, rd and write data. Write data is shown as "-" for non-writing instructions.
  - Trace is suppressed while reset is asserted.
- `CORE_TRACE_EN` undefined:
  - No trace logic or output.
  - Functional behaviour is identical.

## Test plan
- **Reset.** Hold rst=0 for 4 cycles with garbage in ROM -> pc=0x0 and all regfile entries 0. Assert rst mid-run -> pc returns to 0x0 without a clock edge.
- **ALU immediates.** `addi x1,x0,5` then `addi x2,x1,-7` -> after 2 cycles x1=0x5, x2=0xFFFFFFFE. `addi x0,x0,1` -> x0 stays 0.
- **Upper immediates.**
  - `lui x5,0x12345` then `addi x5,x5,0x678` -> x5=0x12345678.
  - `auipc x6,1` at pc 0x8 -> x6=0x1008.
- **Shifts and compares.** x7=0x80000000:
  - `srai x8,x7,4` -> 0xF8000000.
  - `srli x9,x7,4` -> 0x08000000.
  - `slt x10,x7,x0` -> 1.
  - `sltu x11,x7,x0` -> 0.
- **Control flow.**
  - `jal x1,+8` at 0x10 -> x1=0x14, next pc=0x18.
  - `beq` with equal operands taken; `bne` with equal operands falls through (pc+4).
  - `jalr x0,3(x2)` with x2=0x20 -> pc=0x22, which fetches word 0x20.
- **Compliance program.** Load a self-checking program that ends by setting x26=1 and x27=1 and then self-looping -> both registers equal 1 within 1500 cycles; x3 holds the last test number.
